// File: rtl/dual_dispatch_unit.sv
// Dual-slot dispatch buffer between decode and the reservation stations.
// Holds one decoded pair and routes each entry to its unit port.
module dual_dispatch_unit #(
  parameter int PAY_W = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       first_class,
  input  logic [3:0]       second_class,
  input  logic [PAY_W-1:0] first_pay,
  input  logic [PAY_W-1:0] second_pay,
  output logic             alu_valid,
  output logic             mul_valid,
  output logic             fp_valid,
  output logic             mem_valid,
  input  logic             alu_ready,
  input  logic             mul_ready,
  input  logic             fp_ready,
  input  logic             mem_ready,
  output logic [PAY_W-1:0] alu_pay,
  output logic [PAY_W-1:0] mul_pay,
  output logic [PAY_W-1:0] fp_pay,
  output logic [PAY_W-1:0] mem_pay,
  output logic             alu_slot,
  output logic             mul_slot,
  output logic             fp_slot,
  output logic             mem_slot,
  output logic [CNT_W-1:0] stall_cnt
);

  logic             e0_v_q, e0_v_d;
  logic [3:0]       e0_cls_q, e0_cls_d;
  logic [PAY_W-1:0] e0_pay_q, e0_pay_d;
  logic             e1_v_q, e1_v_d;
  logic [3:0]       e1_cls_q, e1_cls_d;
  logic [PAY_W-1:0] e1_pay_q, e1_pay_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [3:0]       rdy;
  logic [3:0]       sel0;
  logic [3:0]       sel1;
  logic [3:0]       uvld;
  logic [PAY_W-1:0] upay [4];
  logic             fire0;
  logic             fire1;
  logic             cap;

  // Multi-hot classes collapse to the lowest set bit (alu first).
  function automatic logic [3:0] lowbit(input logic [3:0] c);
    return c & (~c + 4'd1);
  endfunction

  assign rdy = {mem_ready, fp_ready, mul_ready, alu_ready};

  // Unit selection: E0 has priority on a shared unit.
  always_comb begin
    sel0 = {4{e0_v_q}} & e0_cls_q;
    sel1 = {4{e1_v_q}} & e1_cls_q & ~sel0;
    uvld = sel0 | sel1;
    for (int i = 0; i < 4; i++) begin
      upay[i] = '0;
      if (sel0[i])
        upay[i] = e0_pay_q;
      else if (sel1[i])
        upay[i] = e1_pay_q;
    end
    fire0 = e0_v_q & ((e0_cls_q == 4'd0) | (|(sel0 & rdy)));
    fire1 = e1_v_q & ((e1_cls_q == 4'd0) | (|(sel1 & rdy)));
  end

  assign in_ready  = (~e0_v_q | fire0) & (~e1_v_q | fire1);
  assign cap       = in_valid & in_ready & ~flush;

  assign alu_valid = uvld[0];
  assign mul_valid = uvld[1];
  assign fp_valid  = uvld[2];
  assign mem_valid = uvld[3];
  assign alu_pay   = upay[0];
  assign mul_pay   = upay[1];
  assign fp_pay    = upay[2];
  assign mem_pay   = upay[3];
  assign alu_slot  = sel1[0];
  assign mul_slot  = sel1[1];
  assign fp_slot   = sel1[2];
  assign mem_slot  = sel1[3];
  assign stall_cnt = cnt_q;

  // Entry next state: flush, then capture, then retire fired entries.
  always_comb begin
    e0_v_d   = e0_v_q;
    e0_cls_d = e0_cls_q;
    e0_pay_d = e0_pay_q;
    e1_v_d   = e1_v_q;
    e1_cls_d = e1_cls_q;
    e1_pay_d = e1_pay_q;
    unique case (1'b1)
      flush: begin
        e0_v_d = 1'b0;
        e1_v_d = 1'b0;
      end
      cap: begin
        e0_v_d   = 1'b1;
        e0_cls_d = lowbit(first_class);
        e0_pay_d = first_pay;
        e1_v_d   = 1'b1;
        e1_cls_d = lowbit(second_class);
        e1_pay_d = second_pay;
      end
      default: begin
        if (fire0) e0_v_d = 1'b0;
        if (fire1) e1_v_d = 1'b0;
      end
    endcase
  end

  // Saturating count of cycles where decode was held off.
  always_comb begin
    cnt_d = cnt_q;
    if (in_valid & ~in_ready & ~flush & ~(&cnt_q))
      cnt_d = cnt_q + CNT_W'(1);
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      e0_v_q   <= 1'b0;
      e0_cls_q <= '0;
      e0_pay_q <= '0;
      e1_v_q   <= 1'b0;
      e1_cls_q <= '0;
      e1_pay_q <= '0;
      cnt_q    <= '0;
    end else begin
      e0_v_q   <= e0_v_d;
      e0_cls_q <= e0_cls_d;
      e0_pay_q <= e0_pay_d;
      e1_v_q   <= e1_v_d;
      e1_cls_q <= e1_cls_d;
      e1_pay_q <= e1_pay_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: tb/tb_dual_dispatch_unit.sv
// Scoreboard bench for dual_dispatch_unit.
// Grants are checked by a monitor against per-unit expectation queues.
module tb_dual_dispatch_unit;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid;
  logic [3:0]  first_class, second_class;
  logic [31:0] first_pay, second_pay;
  logic        alu_ready, mul_ready, fp_ready, mem_ready;

  logic        in_ready;
  logic        alu_valid, mul_valid, fp_valid, mem_valid;
  logic [31:0] alu_pay, mul_pay, fp_pay, mem_pay;
  logic        alu_slot, mul_slot, fp_slot, mem_slot;
  logic [15:0] stall_cnt;

  logic        s_in_ready;
  logic        s_alu_valid, s_mul_valid, s_fp_valid, s_mem_valid;
  logic [31:0] s_alu_pay, s_mul_pay, s_fp_pay, s_mem_pay;
  logic        s_alu_slot, s_mul_slot, s_fp_slot, s_mem_slot;
  logic [1:0]  s_stall_cnt;

  int errors = 0;
  int checks = 0;

  logic [32:0] qa[$];
  logic [32:0] qm[$];
  logic [32:0] qf[$];
  logic [32:0] qe[$];

  always #5 clk = ~clk;

  dual_dispatch_unit #(.PAY_W(32), .CNT_W(16)) u_dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .first_class(first_class), .second_class(second_class),
    .first_pay(first_pay), .second_pay(second_pay),
    .alu_valid(alu_valid), .mul_valid(mul_valid),
    .fp_valid(fp_valid), .mem_valid(mem_valid),
    .alu_ready(alu_ready), .mul_ready(mul_ready),
    .fp_ready(fp_ready), .mem_ready(mem_ready),
    .alu_pay(alu_pay), .mul_pay(mul_pay),
    .fp_pay(fp_pay), .mem_pay(mem_pay),
    .alu_slot(alu_slot), .mul_slot(mul_slot),
    .fp_slot(fp_slot), .mem_slot(mem_slot),
    .stall_cnt(stall_cnt)
  );

  dual_dispatch_unit #(.PAY_W(32), .CNT_W(2)) u_sat (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(s_in_ready),
    .first_class(first_class), .second_class(second_class),
    .first_pay(first_pay), .second_pay(second_pay),
    .alu_valid(s_alu_valid), .mul_valid(s_mul_valid),
    .fp_valid(s_fp_valid), .mem_valid(s_mem_valid),
    .alu_ready(alu_ready), .mul_ready(mul_ready),
    .fp_ready(fp_ready), .mem_ready(mem_ready),
    .alu_pay(s_alu_pay), .mul_pay(s_mul_pay),
    .fp_pay(s_fp_pay), .mem_pay(s_mem_pay),
    .alu_slot(s_alu_slot), .mul_slot(s_mul_slot),
    .fp_slot(s_fp_slot), .mem_slot(s_mem_slot),
    .stall_cnt(s_stall_cnt)
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic push(input int u, input logic [31:0] p, input logic s);
    case (u)
      0: qa.push_back({s, p});
      1: qm.push_back({s, p});
      2: qf.push_back({s, p});
      default: qe.push_back({s, p});
    endcase
  endtask

  task automatic mon(input int u, input logic v, input logic r,
                     input logic [31:0] p, input logic s);
    logic [32:0] e;
    bit have;
    have = 1'b0;
    e = '0;
    if (v && r) begin
      case (u)
        0: if (qa.size() > 0) begin e = qa.pop_front(); have = 1'b1; end
        1: if (qm.size() > 0) begin e = qm.pop_front(); have = 1'b1; end
        2: if (qf.size() > 0) begin e = qf.pop_front(); have = 1'b1; end
        default:
           if (qe.size() > 0) begin e = qe.pop_front(); have = 1'b1; end
      endcase
      checks++;
      if (!have) begin
        errors++;
        $display("FAIL grant_unit%0d: got pay=%h slot=%0d expected none",
                 u, p, s);
      end else if ({s, p} !== e) begin
        errors++;
        $display("FAIL grant_unit%0d: got pay=%h slot=%0d expected pay=%h slot=%0d",
                 u, p, s, e[31:0], e[32]);
      end
    end
  endtask

  // Handshakes are sampled mid-cycle, away from the clock edge.
  always @(negedge clk) begin
    if (!rst) begin
      mon(0, alu_valid, alu_ready, alu_pay, alu_slot);
      mon(1, mul_valid, mul_ready, mul_pay, mul_slot);
      mon(2, fp_valid, fp_ready, fp_pay, fp_slot);
      mon(3, mem_valid, mem_ready, mem_pay, mem_slot);
    end
  end

  task automatic step;
    @(posedge clk);
    #2;
  endtask

  task automatic drive(input logic [3:0] c0, input logic [31:0] p0,
                       input logic [3:0] c1, input logic [31:0] p1);
    in_valid     = 1'b1;
    first_class  = c0;
    first_pay    = p0;
    second_class = c1;
    second_pay   = p1;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0;
    first_class = '0; second_class = '0;
    first_pay = '0; second_pay = '0;
    alu_ready = 1'b1; mul_ready = 1'b1;
    fp_ready = 1'b1; mem_ready = 1'b1;

    // reset then idle
    step;
    step;
    chk("rst_valids", {alu_valid, mul_valid, fp_valid, mem_valid}, 0);
    chk("rst_pays", alu_pay | mul_pay | fp_pay | mem_pay, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_stall", stall_cnt, 0);
    rst = 1'b0;
    step;

    // independent alu/mul pairs back to back
    for (int i = 0; i < 4; i++) begin
      if (i > 0) begin
        chk("b2b_ready", in_ready, 1);
        chk("b2b_valids", {alu_valid, mul_valid}, 2'b11);
      end
      drive(4'b0001, 32'hA + 32'(i * 16), 4'b0010, 32'hB + 32'(i * 16));
      push(0, 32'hA + 32'(i * 16), 1'b0);
      push(1, 32'hB + 32'(i * 16), 1'b1);
      step;
    end
    chk("b2b_last_valids", {alu_valid, mul_valid}, 2'b11);
    in_valid = 1'b0;
    step;
    chk("b2b_idle", {alu_valid, mul_valid, fp_valid, mem_valid}, 0);
    chk("b2b_no_stall", stall_cnt, 0);

    // same-unit conflict on fp
    drive(4'b0100, 32'h1, 4'b0100, 32'h2);
    push(2, 32'h1, 1'b0);
    push(2, 32'h2, 1'b1);
    step;
    in_valid = 1'b0;
    chk("conf_n1_ready", in_ready, 0);
    chk("conf_n1_slot", fp_slot, 0);
    step;
    chk("conf_n2_ready", in_ready, 1);
    chk("conf_n2_slot", fp_slot, 1);
    step;
    chk("conf_idle", fp_valid, 0);

    // backpressure on mem with decode held
    mem_ready = 1'b0;
    drive(4'b1000, 32'h55, 4'b1000, 32'h66);
    push(3, 32'h55, 1'b0);
    push(3, 32'h66, 1'b1);
    step;
    for (int k = 0; k < 5; k++) begin
      chk("bp_pay", mem_pay, 32'h55);
      chk("bp_ready", in_ready, 0);
      step;
    end
    chk("bp_stall", stall_cnt, 5);
    mem_ready = 1'b1;
    in_valid = 1'b0;
    step;
    chk("bp_drain_slot", {mem_valid, mem_slot}, 2'b11);
    chk("bp_drain_ready", in_ready, 1);
    step;
    chk("bp_empty", mem_valid, 0);

    // flush while both entries wait on alu
    alu_ready = 1'b0;
    drive(4'b0001, 32'h77, 4'b0001, 32'h88);
    step;
    drive(4'b0010, 32'h99, 4'b0010, 32'h9A);
    chk("fl_pending", {alu_valid, in_ready}, 2'b10);
    step;
    chk("fl_pre_stall", stall_cnt, 6);
    flush = 1'b1;
    step;
    chk("fl_valids", {alu_valid, mul_valid, fp_valid, mem_valid}, 0);
    chk("fl_stall_hold", stall_cnt, 6);
    flush = 1'b0;
    in_valid = 1'b0;
    alu_ready = 1'b1;
    step;
    chk("fl_idle", {alu_valid, mul_valid}, 0);

    // nop in slot 0, multi-hot in slot 1 resolves to mul
    drive(4'b0000, 32'hC0, 4'b1010, 32'hC1);
    push(1, 32'hC1, 1'b1);
    step;
    in_valid = 1'b0;
    chk("nop_others", {alu_valid, fp_valid, mem_valid}, 0);
    chk("nop_mul", {mul_valid, mul_slot}, 2'b11);
    chk("nop_ready", in_ready, 1);
    step;
    chk("nop_idle", {alu_valid, mul_valid, fp_valid, mem_valid}, 0);

    // saturation of a 2-bit counter
    rst = 1'b1;
    step;
    rst = 1'b0;
    chk("sat_rst", s_stall_cnt, 0);
    mem_ready = 1'b0;
    drive(4'b1000, 32'hD0, 4'b1000, 32'hD1);
    push(3, 32'hD0, 1'b0);
    push(3, 32'hD1, 1'b1);
    step;
    repeat (6) step;
    chk("sat_main", stall_cnt, 6);
    chk("sat_small", s_stall_cnt, 3);
    mem_ready = 1'b1;
    in_valid = 1'b0;
    step;
    step;
    step;

    chk("left_alu", qa.size(), 0);
    chk("left_mul", qm.size(), 0);
    chk("left_fp", qf.size(), 0);
    chk("left_mem", qe.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
